// File: rtl/conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_scheduler
// Purpose  : Sequences every kernel tap of a valid-mode 2-D convolution and
//            drives ROM addresses, MAC control and output writes. The optional
//            busy-cycle counter port is enabled by defining CONV_CYCLE_CNT_EN.
// Revision : 1.0
// ============================================================================
module conv_window_scheduler #(
    parameter int IMG_SIZE = 10,
    parameter int KER_SIZE = 3,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] k_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr
`ifdef CONV_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam int OUT = IMG_SIZE - KER_SIZE + 1;
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_MAX = ADDR_W'(KER_SIZE - 1);
    localparam logic [ADDR_W-1:0] O_MAX = ADDR_W'(OUT - 1);
    localparam logic [ADDR_W-1:0] IMG_W = ADDR_W'(IMG_SIZE);
    localparam logic [ADDR_W-1:0] KER_W = ADDR_W'(KER_SIZE);
    localparam logic [ADDR_W-1:0] OUT_W = ADDR_W'(OUT);

    if (KER_SIZE < 1 || KER_SIZE > IMG_SIZE) begin : g_ker_check
        $error("conv_window_scheduler: KER_SIZE must be in 1..IMG_SIZE");
    end
    if (longint'(IMG_SIZE) * longint'(IMG_SIZE) > (longint'(1) << ADDR_W)) begin : g_addr_check
        $error("conv_window_scheduler: IMG_SIZE*IMG_SIZE exceeds ADDR_W address space");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] orow, ocol, kr, kc;
    logic [ADDR_W-1:0] orow_nx, ocol_nx, kr_nx, kc_nx;
    logic [ADDR_W-1:0] im_nx, k_nx;
    logic              first_tap, pix_last, run_last, advance;

    // Delay stage aligned with the 1-cycle ROM latency, then the write stage.
    logic              d_vld, d_clr, d_last;
    logic [ADDR_W-1:0] d_pix;
    logic              we_q;

    assign first_tap = (kr == '0) && (kc == '0);
    assign pix_last  = (kr == K_MAX) && (kc == K_MAX);
    assign run_last  = pix_last && (orow == O_MAX) && (ocol == O_MAX);
    assign advance   = !hold || (state == IDLE) || (state == FIN);

    assign im_nx = (orow_nx + kr_nx) * IMG_W + ocol_nx + kc_nx;
    assign k_nx  = kr_nx * KER_W + kc_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        orow_nx  = orow;
        ocol_nx  = ocol;
        kr_nx    = kr;
        kc_nx    = kc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    orow_nx  = '0;
                    ocol_nx  = '0;
                    kr_nx    = '0;
                    kc_nx    = '0;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (run_last) begin
                        state_nx = DRAIN;
                    end else if (kc != K_MAX) begin
                        kc_nx = kc + ONE;
                    end else begin
                        kc_nx = '0;
                        if (kr != K_MAX) begin
                            kr_nx = kr + ONE;
                        end else begin
                            kr_nx = '0;
                            if (ocol != O_MAX) begin
                                ocol_nx = ocol + ONE;
                            end else begin
                                ocol_nx = '0;
                                orow_nx = orow + ONE;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                // The write stage drains on the same edge that enters FIN.
                if (!hold && !d_vld) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            orow     <= '0;
            ocol     <= '0;
            kr       <= '0;
            kc       <= '0;
            d_vld    <= 1'b0;
            d_clr    <= 1'b0;
            d_last   <= 1'b0;
            d_pix    <= '0;
            we_q     <= 1'b0;
            im_addr  <= '0;
            k_addr   <= '0;
            out_addr <= '0;
        end else if (advance) begin
            orow   <= orow_nx;
            ocol   <= ocol_nx;
            kr     <= kr_nx;
            kc     <= kc_nx;
            d_vld  <= (state == RUN);
            d_clr  <= first_tap;
            d_last <= pix_last;
            d_pix  <= orow * OUT_W + ocol;
            we_q   <= d_vld && d_last;
            if (d_vld && d_last) begin
                out_addr <= d_pix;
            end else if (state_nx == FIN) begin
                out_addr <= '0;
            end
            if (state_nx == RUN) begin
                im_addr <= im_nx;
                k_addr  <= k_nx;
            end else if (state_nx != DRAIN) begin
                im_addr <= '0;
                k_addr  <= '0;
            end
        end
    end

    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == FIN);
    assign mac_en  = d_vld && !hold;
    assign mac_clr = d_vld && d_clr && !hold;
    assign out_we  = we_q && !hold;

`ifdef CONV_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
        end else if (busy) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_scheduler
// Purpose  : Directed bench for conv_window_scheduler (default and 4x4/1x1).
// Revision : 1.0
// ============================================================================
module tb_conv_window_scheduler;

    localparam int IMGD = 10;
    localparam int KD   = 3;
    localparam int OUTD = IMGD - KD + 1;
    localparam int TAPS = KD * KD;
    localparam int N    = OUTD * OUTD * TAPS;
    localparam int AW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          busy, done, mac_clr, mac_en, out_we;
    logic [AW-1:0] im_addr, k_addr, out_addr;

    logic          start1 = 1'b0;
    logic          hold1 = 1'b0;
    logic          busy1, done1, mac_clr1, mac_en1, out_we1;
    logic [AW-1:0] im_addr1, k_addr1, out_addr1;

`ifdef CONV_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt, cycle_cnt1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_window_scheduler #(.IMG_SIZE(IMGD), .KER_SIZE(KD), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .im_addr  (im_addr),
        .k_addr   (k_addr),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .out_we   (out_we),
        .out_addr (out_addr)
`ifdef CONV_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    conv_window_scheduler #(.IMG_SIZE(4), .KER_SIZE(1), .ADDR_W(AW)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .hold     (hold1),
        .busy     (busy1),
        .done     (done1),
        .im_addr  (im_addr1),
        .k_addr   (k_addr1),
        .mac_clr  (mac_clr1),
        .mac_en   (mac_en1),
        .out_we   (out_we1),
        .out_addr (out_addr1)
`ifdef CONV_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt1)
`endif
    );

    function automatic int tap_im(input int j);
        int pix = j / TAPS;
        int t   = j % TAPS;
        return (pix / OUTD + t / KD) * IMGD + (pix % OUTD) + (t % KD);
    endfunction

    function automatic int tap_k(input int j);
        return j % TAPS;
    endfunction

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, c, obs, expv);
        end
    endtask

    task automatic check_zero(input int c);
        chk("rst_busy", c, busy, 0);
        chk("rst_done", c, done, 0);
        chk("rst_im_addr", c, im_addr, 0);
        chk("rst_k_addr", c, k_addr, 0);
        chk("rst_mac_en", c, mac_en, 0);
        chk("rst_mac_clr", c, mac_clr, 0);
        chk("rst_out_we", c, out_we, 0);
        chk("rst_out_addr", c, out_addr, 0);
`ifdef CONV_CYCLE_CNT_EN
        chk("rst_cycle_cnt", c, cycle_cnt, 0);
`endif
    endtask

    // One pass on the default instance. Cycle c is counted from the start
    // edge; e is the equivalent cycle of an unheld run.
    task automatic run_default(input int h1s, input int h1n, input int h2s, input int h2n,
                               input int rs1, input int rs2, input int abort_at);
        int  e, c, n_we, j, jm, jw;
        bit  h, en, we;
        @(posedge clk); #1;
        start = 1'b1;
        hold  = 1'b0;
        e = 1; c = 0; n_we = 0;
        while (e <= N + 5 && c < 2000) begin
            c++;
            @(posedge clk); #1;
            h = (c >= h1s && c < h1s + h1n) || (c >= h2s && c < h2s + h2n);
            hold  = h;
            start = (c == rs1 || c == rs2);
            if (c == abort_at) begin
                rst   = 1'b0;
                start = 1'b1;
            end
            @(negedge clk);
            if (e >= 1 && e <= N) j = e - 1;
            else if (e == N + 1 || e == N + 2) j = N - 1;
            else j = -1;
            jm = e - 2;
            jw = e - 3;
            en = !h && jm >= 0 && jm < N;
            we = !h && jw >= 0 && jw < N && (jw % TAPS) == TAPS - 1;
            chk("busy", c, busy, (e >= 1 && e <= N + 2));
            chk("done", c, done, (e == N + 3));
            chk("im_addr", c, im_addr, (j >= 0) ? tap_im(j) : 0);
            chk("k_addr", c, k_addr, (j >= 0) ? tap_k(j) : 0);
            chk("mac_en", c, mac_en, en);
            chk("mac_clr", c, mac_clr, en && (jm % TAPS) == 0);
            chk("out_we", c, out_we, we);
            if (we) chk("out_addr", c, out_addr, jw / TAPS);
`ifdef CONV_CYCLE_CNT_EN
            if (e == N + 3) chk("cycle_cnt", c, cycle_cnt, c - 1);
`endif
            if (out_we) n_we++;
            if (c == abort_at) break;
            if (!h) e++;
        end
        hold  = 1'b0;
        start = 1'b0;
        if (abort_at > 0) begin
            @(posedge clk); #1;
            rst = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                check_zero(c + i);
                if (i < 4) @(posedge clk);
            end
        end else begin
            chk("out_we_count", c, n_we, OUTD * OUTD);
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0);
        chk("rst1_busy", 0, busy1, 0);
        chk("rst1_im_addr", 0, im_addr1, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Clean pass, then two hold windows (second spans a write), then
        // ignored re-starts, then a reset abort followed by a fresh pass.
        run_default(0, 0, 0, 0, 0, 0, 0);
        run_default(20, 5, 43, 3, 0, 0, 0);
        run_default(0, 0, 0, 0, 50, N + 2, 0);
        run_default(0, 0, 0, 0, 0, 0, 100);
        run_default(0, 0, 0, 0, 0, 0, 0);

        // 4x4 image, 1x1 kernel: every tap is its own output pixel.
        @(posedge clk); #1;
        start1 = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            @(negedge clk);
            chk("k1_im_addr", c, im_addr1, (c <= 16) ? c - 1 : ((c <= 18) ? 15 : 0));
            chk("k1_k_addr", c, k_addr1, 0);
            chk("k1_mac_en", c, mac_en1, (c >= 2 && c <= 17));
            chk("k1_mac_clr", c, mac_clr1, (c >= 2 && c <= 17));
            chk("k1_out_we", c, out_we1, (c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) chk("k1_out_addr", c, out_addr1, c - 3);
            chk("k1_busy", c, busy1, (c <= 18));
            chk("k1_done", c, done1, (c == 19));
`ifdef CONV_CYCLE_CNT_EN
            if (c == 19) chk("k1_cycle_cnt", c, cycle_cnt1, 18);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
